// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, reads combinational imem and buffers {pc, instr} in a prefetch queue for decode
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] IMEM_LAST = 32'd84
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_en,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  output logic                     if_valid,
  output logic [31:0]              if_instr,
  output logic [31:0]              if_pc,
  input  logic                     if_ready,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     fetch_done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [31:0]   pc;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          push, pop;
  logic          unused_bits;

  assign unused_bits = ^redirect_pc[1:0];
  assign imem_addr   = pc;
  assign if_valid    = count != '0;
  assign if_instr    = if_valid ? instr_mem[rd_ptr] : '0;
  assign if_pc       = if_valid ? pc_mem[rd_ptr] : '0;
  assign q_count     = count;
  assign fetch_done  = state == DONE;
  // a redirect cycle suppresses both queue operations
  assign pop  = if_valid & if_ready & ~redirect_valid;
  assign push = ~redirect_valid & (state == FETCH) & fetch_en & (pc <= IMEM_LAST) & ((count != FULL) | pop);

  always_comb
    state_nxt = (redirect_valid || state == IDLE) ? (fetch_en ? FETCH : IDLE)
              : state == FETCH ? (!fetch_en ? IDLE : pc > IMEM_LAST ? DONE : FETCH)
              : DONE;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        pc     <= {redirect_pc[31:2], 2'b00};
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc     <= pc + 32'd4;
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
    end

  always_ff @(posedge clk)
    if (push) begin
      pc_mem[wr_ptr]    <= pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench; expected PCs queued up front, compared as decode pops them
module tb_fetch_sequencer;
  logic        clk = 0, rst_n = 0, fetch_en = 0, if_ready = 0, redirect_valid = 0;
  logic [31:0] redirect_pc = 0, imem_addr, imem_rdata, if_instr, if_pc;
  logic        if_valid, fetch_done;
  logic [2:0]  q_count;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;
  assign imem_rdata = 32'hA000_0000 | imem_addr;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .q_count(q_count), .fetch_done(fetch_done)
  );

  task do_reset;
    rst_n = 0; fetch_en = 0; if_ready = 0; redirect_valid = 0; redirect_pc = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task test_reset;
    fetch_en = 1; if_ready = 1;
    repeat (2) @(negedge clk);
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", if_valid); end
    n_cmp++; if (q_count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", q_count); end
    n_cmp++; if (fetch_done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", fetch_done); end
    n_cmp++; if (imem_addr !== 32'd0) begin n_err++; $display("FAIL rst_addr got %h want 0", imem_addr); end
    n_cmp++; if (if_instr !== 32'd0 || if_pc !== 32'd0) begin n_err++; $display("FAIL rst_head got %h/%h want 0/0", if_pc, if_instr); end
  endtask

  task test_straight;
    int first; bit seen84; logic [31:0] e;
    first = -1; seen84 = 0;
    do_reset;
    for (int a = 0; a <= 84; a += 4) exp_q.push_back(a);
    fetch_en = 1; if_ready = 1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (if_valid && first < 0) first = c;
      if (seen84) begin
        seen84 = 0;
        n_cmp++; if (fetch_done !== 1'b1 || if_valid !== 1'b0) begin n_err++; $display("FAIL sl_end got done %b valid %b want 1 0", fetch_done, if_valid); end
      end
      if (if_valid && if_pc == 32'd84) begin
        seen84 = 1;
        n_cmp++; if (fetch_done !== 1'b0) begin n_err++; $display("FAIL sl_done_early got %b want 0", fetch_done); end
      end
      if (if_valid && if_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL sl_extra got pc %h want none", if_pc); end
        else begin
          e = exp_q.pop_front();
          if (if_pc !== e || if_instr !== (32'hA000_0000 | e)) begin n_err++; $display("FAIL sl_head got %h/%h want %h/%h", if_pc, if_instr, e, 32'hA000_0000 | e); end
        end
      end
    end
    n_cmp++; if (first !== 2) begin n_err++; $display("FAIL sl_latency got %0d want 2", first); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL sl_left got %0d want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task test_backpressure;
    logic [31:0] e;
    do_reset;
    fetch_en = 1; if_ready = 0;
    repeat (8) @(negedge clk);
    n_cmp++; if (q_count !== 3'd4) begin n_err++; $display("FAIL bp_count got %0d want 4", q_count); end
    n_cmp++; if (imem_addr !== 32'd16) begin n_err++; $display("FAIL bp_addr got %h want 10", imem_addr); end
    n_cmp++; if (if_pc !== 32'd0) begin n_err++; $display("FAIL bp_head got %h want 0", if_pc); end
    if_ready = 1;
    @(negedge clk);
    if_ready = 0;
    n_cmp++; if (q_count !== 3'd4 || if_pc !== 32'd4 || imem_addr !== 32'd20) begin n_err++; $display("FAIL bp_swap got cnt %0d pc %h addr %h want 4 4 14", q_count, if_pc, imem_addr); end
    for (int a = 4; a <= 24; a += 4) exp_q.push_back(a);
    if_ready = 1;
    for (int i = 0; i < 6; i++) begin
      if (if_valid && if_ready) begin
        n_cmp++;
        e = exp_q.pop_front();
        if (if_pc !== e || if_instr !== (32'hA000_0000 | e)) begin n_err++; $display("FAIL bp_drain got %h/%h want %h/%h", if_pc, if_instr, e, 32'hA000_0000 | e); end
      end
      @(negedge clk);
    end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL bp_left got %0d want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task test_redirect;
    logic [31:0] e;
    do_reset;
    fetch_en = 1; if_ready = 0;
    repeat (6) @(negedge clk);
    if_ready = 1;
    repeat (2) @(negedge clk);
    n_cmp++; if (if_pc !== 32'd8 || q_count !== 3'd4) begin n_err++; $display("FAIL rd_pre got pc %h cnt %0d want 8 4", if_pc, q_count); end
    redirect_valid = 1; redirect_pc = 32'h3E;
    @(negedge clk);
    redirect_valid = 0;
    n_cmp++; if (q_count !== 3'd0 || if_valid !== 1'b0) begin n_err++; $display("FAIL rd_flush got cnt %0d valid %b want 0 0", q_count, if_valid); end
    n_cmp++; if (imem_addr !== 32'h3C) begin n_err++; $display("FAIL rd_addr got %h want 3c", imem_addr); end
    exp_q = '{32'h3C, 32'h40, 32'h44};
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      if (if_valid && if_ready) begin
        n_cmp++;
        e = exp_q.pop_front();
        if (if_pc !== e || if_instr !== (32'hA000_0000 | e)) begin n_err++; $display("FAIL rd_head got %h/%h want %h/%h", if_pc, if_instr, e, 32'hA000_0000 | e); end
      end
      @(negedge clk);
    end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL rd_left got %0d want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task test_pause_end;
    bit paused, resumed; int hold; logic [31:0] e;
    paused = 0; resumed = 0; hold = 0;
    do_reset;
    for (int a = 0; a <= 84; a += 4) exp_q.push_back(a);
    fetch_en = 1; if_ready = 1;
    for (int c = 0; c < 80; c++) begin
      if (if_valid && if_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL pe_extra got pc %h want none", if_pc); end
        else begin
          e = exp_q.pop_front();
          if (if_pc !== e || if_instr !== (32'hA000_0000 | e)) begin n_err++; $display("FAIL pe_head got %h/%h want %h/%h", if_pc, if_instr, e, 32'hA000_0000 | e); end
        end
      end
      if (!paused && imem_addr == 32'd40) begin
        fetch_en = 0; paused = 1;
      end else if (paused && !resumed) begin
        hold++;
        if (hold == 5) begin
          n_cmp++; if (imem_addr !== 32'd40 || q_count !== 3'd0) begin n_err++; $display("FAIL pe_hold got addr %h cnt %0d want 28 0", imem_addr, q_count); end
          fetch_en = 1; resumed = 1;
        end
      end
      @(negedge clk);
    end
    n_cmp++; if (exp_q.size() !== 0 || !resumed) begin n_err++; $display("FAIL pe_left got %0d resumed %b want 0 1", exp_q.size(), resumed); end
    n_cmp++; if (fetch_done !== 1'b1) begin n_err++; $display("FAIL pe_done got %b want 1", fetch_done); end
    redirect_valid = 1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 0;
    n_cmp++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL pe_far_addr got %h want 100", imem_addr); end
    @(negedge clk);
    n_cmp++; if (fetch_done !== 1'b1 || q_count !== 3'd0) begin n_err++; $display("FAIL pe_far_end got done %b cnt %0d want 1 0", fetch_done, q_count); end
    redirect_valid = 1; redirect_pc = 32'h0;
    @(negedge clk);
    redirect_valid = 0;
    n_cmp++; if (fetch_done !== 1'b0 || imem_addr !== 32'd0) begin n_err++; $display("FAIL pe_restart got done %b addr %h want 0 0", fetch_done, imem_addr); end
    exp_q = '{32'h0, 32'h4};
    for (int i = 0; i < 6 && exp_q.size() != 0; i++) begin
      if (if_valid && if_ready) begin
        n_cmp++;
        e = exp_q.pop_front();
        if (if_pc !== e || if_instr !== (32'hA000_0000 | e)) begin n_err++; $display("FAIL pe_rehead got %h/%h want %h/%h", if_pc, if_instr, e, 32'hA000_0000 | e); end
      end
      @(negedge clk);
    end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL pe_releft got %0d want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task test_async_reset;
    int c; logic [31:0] e;
    do_reset;
    fetch_en = 1; if_ready = 0;
    c = 0;
    while (q_count != 3'd3 && c < 10) begin @(negedge clk); c++; end
    n_cmp++; if (q_count !== 3'd3) begin n_err++; $display("FAIL ar_fill got %0d want 3", q_count); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if (if_valid !== 1'b0 || q_count !== 3'd0 || fetch_done !== 1'b0) begin n_err++; $display("FAIL ar_clear got valid %b cnt %0d done %b want 0 0 0", if_valid, q_count, fetch_done); end
    n_cmp++; if (imem_addr !== 32'd0) begin n_err++; $display("FAIL ar_addr got %h want 0", imem_addr); end
    @(negedge clk);
    rst_n = 1; if_ready = 1;
    exp_q = '{32'h0, 32'h4, 32'h8};
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
      if (if_valid && if_ready) begin
        n_cmp++;
        e = exp_q.pop_front();
        if (if_pc !== e || if_instr !== (32'hA000_0000 | e)) begin n_err++; $display("FAIL ar_head got %h/%h want %h/%h", if_pc, if_instr, e, 32'hA000_0000 | e); end
      end
      @(negedge clk);
    end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL ar_left got %0d want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    test_reset;
    test_straight;
    test_backpressure;
    test_redirect;
    test_pause_end;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that sequences reads of the combinational, byte-addressed instruction memory.
- Owns the PC and drives the memory read address.
- Captures each returned word with its PC into a small prefetch queue.
- Hands the entries to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and reloading the PC.
- Stops fetching past the last populated memory word.

Parameters:
RESET_PC, 32'd0, PC value after reset.
DEPTH, 4, prefetch queue entries; power of two, at least 2.
IMEM_LAST, 32'd84, last valid word byte address in instruction memory.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
fetch_en  input  1  enables fetching; low pauses without losing state.
imem_addr  output  32  byte address to instruction memory; equals PC.
imem_rdata  input  32  instruction word from memory, same-cycle (combinational) return.
if_valid  output  1  head queue entry is valid.
if_instr  output  32  head instruction.
if_pc  output  32  PC of head instruction.
if_ready  input  1  decode accepts head this cycle.
redirect_valid  input  1  redirect request (taken branch/jump).
redirect_pc  input  32  redirect target.
q_count  output  $clog2(DEPTH)+1  current queue occupancy.
fetch_done  output  1  PC beyond IMEM_LAST; fetching has ended.

Behaviour:
Reset (async, rst_n=0):
- pc=RESET_PC, state=IDLE, queue pointers and count = 0.
- if_valid=0, if_instr=0, if_pc=0, q_count=0, fetch_done=0, imem_addr=RESET_PC.
- Takes effect immediately, including mid-operation; all queued entries are discarded.

Datapath:
- imem_addr = pc, combinational.
- pc advances by +4 per push; 32-bit wrap is ignored (bounded by IMEM_LAST).
- if_instr and if_pc show the head entry when if_valid=1 and read 0 when if_valid=0.
- if_valid = (count != 0).

States: IDLE, FETCH, END.
- IDLE: no push. Goes to FETCH the next cycle when fetch_en=1.
- FETCH:
  - If fetch_en=0, go to IDLE; pc and queue are held.
  - Else if pc > IMEM_LAST: no push; go to END.
  - Else push {pc, imem_rdata} when count<DEPTH, or when count==DEPTH and a pop occurs the same cycle; then pc <= pc+4.
  - Else (queue full, no pop): stall; pc is held.
- END: no pushes; fetch_done=1 (registered, from state==END). Decode may still drain the queue.

Queue rules:
- Pop = if_valid & if_ready.
- Push and pop in the same cycle leave count unchanged.
- Pop on an empty queue is ignored.
- An entry pushed in cycle N is visible at if_* from cycle N+1 (one-cycle latency). Sustained throughput is 1 instruction/cycle.

Redirect (highest priority, any state):
- On a clock edge with redirect_valid=1: count=0 and pointers cleared, pc <= {redirect_pc[31:2],2'b00}.
- No push and no pop take effect that cycle, even if if_ready=1.
- Next state is FETCH if fetch_en=1, else IDLE. This exits END; fetch_done drops the next cycle.
- A redirect target > IMEM_LAST goes FETCH -> END via the normal rule.

Reset and redirect in the same cycle: reset wins.

Test Plan:
1. Straight-line fetch. Bench memory returns 0xA000_0000|addr. Release reset, fetch_en=1, if_ready=1 -> first if_valid 2 cycles after fetch_en is sampled, with if_pc=0, if_instr=0xA000_0000. Then one entry per cycle: pc 4, 8, ... 84, if_instr=0xA000_0054 last. fetch_done=1 after the 84 entry is pushed and the pc=88 check cycle completes; no entry with if_pc=88 ever appears.
2. Backpressure. if_ready=0 with DEPTH=4 -> q_count reaches 4, pc holds at 16, imem_addr=16. Assert if_ready for 1 cycle -> pop pc 0 and push pc 16 in the same cycle; q_count stays 4; next head if_pc=4.
3. Redirect flush. With queue holding pc 8..20, pulse redirect_valid with redirect_pc=0x3E -> next cycle q_count=0, if_valid=0, imem_addr=0x3C. if_ready held high that cycle pops nothing. Next entry out has if_pc=0x3C.
4. Pause and end. Drop fetch_en mid-stream at pc=40 -> state IDLE, pc frozen at 40, queue drains to 0. Re-raise -> resumes at pc=40 with no skipped or duplicated PCs. Redirect to 0x100 -> END, fetch_done=1. Redirect to 0 -> fetch_done=0 the next cycle and fetching restarts.
5. Async reset mid-run. Assert rst_n=0 between clock edges with q_count=3 -> if_valid, q_count, fetch_done drop to 0 immediately and imem_addr=RESET_PC without waiting for a clock edge. After release, the sequence restarts from pc=0.
